// File: rtl/ar_id_allocator.sv
// ar_id_allocator
//
// AR-channel stage that sits directly upstream of the R-channel same-ID
// ordering unit. Each original ARID in flight is bound to a row. Each
// outstanding transaction of that ID holds one column of the row. The AR is
// forwarded to the slave with the internal ID {row,col}. The same row table
// also restores the original ID for R beats through a combinational lookup.
//
// Ports
//   clk, rst_n           clock and asynchronous active-low reset
//   ar_in_*              master-side AR channel; ar_in_id is the original ARID
//   ar_out_*             slave-side AR channel from a one-entry output
//                        register; ar_out_id is {row,col}, zero-extended
//   alloc_evt_*          one-cycle event per accepted AR, carrying the slot
//                        it was given. It rises together with ar_out_valid.
//   free_req/row/col     retire pulse from the ordering unit
//   lookup_row/col       internal tag of the current R beat
//   lookup_id            original ID bound to lookup_row (combinational)
//   err_bad_free         one-cycle pulse after a free of a slot that is not busy
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The sender holds valid and all payload fields stable until that transfer
// and never withdraws valid. Ready may depend combinationally on the state.
// On this block, ar_in_ready also depends on ar_out_ready, so the output
// register can be refilled in the same cycle it drains.

module ar_id_allocator #(
    parameter int NUM_ROWS   = 4,
    parameter int NUM_COLS   = 4,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    localparam int ROW_W     = $clog2(NUM_ROWS),
    localparam int COL_W     = $clog2(NUM_COLS)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // master-side AR
    input  logic                  ar_in_valid,
    output logic                  ar_in_ready,
    input  logic [ID_WIDTH-1:0]   ar_in_id,
    input  logic [ADDR_WIDTH-1:0] ar_in_addr,
    input  logic [7:0]            ar_in_len,
    input  logic [2:0]            ar_in_size,
    input  logic [1:0]            ar_in_burst,
    input  logic                  ar_in_lock,
    input  logic [3:0]            ar_in_cache,
    input  logic [2:0]            ar_in_prot,
    input  logic [3:0]            ar_in_qos,

    // slave-side AR
    output logic                  ar_out_valid,
    input  logic                  ar_out_ready,
    output logic [ID_WIDTH-1:0]   ar_out_id,
    output logic [ADDR_WIDTH-1:0] ar_out_addr,
    output logic [7:0]            ar_out_len,
    output logic [2:0]            ar_out_size,
    output logic [1:0]            ar_out_burst,
    output logic                  ar_out_lock,
    output logic [3:0]            ar_out_cache,
    output logic [2:0]            ar_out_prot,
    output logic [3:0]            ar_out_qos,

    // allocation event towards the ordering unit
    output logic                  alloc_evt_valid,
    output logic [ROW_W-1:0]      alloc_evt_row,
    output logic [COL_W-1:0]      alloc_evt_col,

    // retire from the ordering unit
    input  logic                  free_req,
    input  logic [ROW_W-1:0]      free_row,
    input  logic [COL_W-1:0]      free_col,

    // tag map for the R path
    input  logic [ROW_W-1:0]      lookup_row,
    input  logic [COL_W-1:0]      lookup_col,
    output logic [ID_WIDTH-1:0]   lookup_id,

    output logic                  err_bad_free
);

    // ------------------------------------------------------------------
    // Binding state
    // ------------------------------------------------------------------
    logic [NUM_ROWS-1:0] row_valid;
    logic [ID_WIDTH-1:0] row_id [NUM_ROWS];
    logic [NUM_COLS-1:0] busy   [NUM_ROWS];

    // ------------------------------------------------------------------
    // Row / column selection for the request at ar_in
    // ------------------------------------------------------------------
    logic             hit;
    logic [ROW_W-1:0] hit_row;
    logic             hit_col_found;
    logic [COL_W-1:0] hit_col;
    logic             empty_found;
    logic [ROW_W-1:0] empty_row;
    logic             can_alloc;
    logic [ROW_W-1:0] sel_row;
    logic [COL_W-1:0] sel_col;
    logic             fire;

    always_comb begin
        hit           = 1'b0;
        hit_row       = '0;
        hit_col_found = 1'b0;
        hit_col       = '0;
        empty_found   = 1'b0;
        empty_row     = '0;

        // At most one valid row can carry a given ID, so the match is unique.
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_valid[r] && (row_id[r] == ar_in_id)) begin
                hit     = 1'b1;
                hit_row = ROW_W'(r);
            end
        end

        // Lowest free column of the hit row.
        for (int c = 0; c < NUM_COLS; c++) begin
            if (!hit_col_found && !busy[hit_row][c]) begin
                hit_col_found = 1'b1;
                hit_col       = COL_W'(c);
            end
        end

        // Lowest unbound row for a new ID.
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!empty_found && !row_valid[r]) begin
                empty_found = 1'b1;
                empty_row   = ROW_W'(r);
            end
        end

        // A full row stalls its ID; it never spills into another row.
        if (hit) begin
            can_alloc = hit_col_found;
            sel_row   = hit_row;
            sel_col   = hit_col;
        end else begin
            can_alloc = empty_found;
            sel_row   = empty_row;
            sel_col   = '0;
        end
    end

    assign ar_in_ready = can_alloc && (!ar_out_valid || ar_out_ready);
    assign fire        = ar_in_valid && ar_in_ready;

    // ------------------------------------------------------------------
    // Next-state of the binding table
    // ------------------------------------------------------------------
    logic                busy_bit_at_free;
    logic                free_hit;
    logic [NUM_COLS-1:0] busy_nxt      [NUM_ROWS];
    logic [NUM_ROWS-1:0] row_valid_nxt;

    assign busy_bit_at_free = busy[free_row][free_col];
    assign free_hit         = free_req && busy_bit_at_free;

    always_comb begin
        row_valid_nxt = row_valid;
        for (int r = 0; r < NUM_ROWS; r++) begin
            busy_nxt[r] = busy[r];
        end

        // The allocation was chosen from the pre-free bitmap. A freed column
        // is busy at that point, so fire and free never touch the same bit.
        if (fire) begin
            busy_nxt[sel_row][sel_col] = 1'b1;
            row_valid_nxt[sel_row]     = 1'b1;
        end

        // A same-cycle fire into the freed row has already set a bit here,
        // so that row keeps its binding.
        if (free_hit) begin
            busy_nxt[free_row][free_col] = 1'b0;
            if (busy_nxt[free_row] == '0) begin
                row_valid_nxt[free_row] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_valid       <= '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                row_id[r] <= '0;
                busy[r]   <= '0;
            end
            ar_out_valid    <= 1'b0;
            ar_out_id       <= '0;
            ar_out_addr     <= '0;
            ar_out_len      <= '0;
            ar_out_size     <= '0;
            ar_out_burst    <= '0;
            ar_out_lock     <= 1'b0;
            ar_out_cache    <= '0;
            ar_out_prot     <= '0;
            ar_out_qos      <= '0;
            alloc_evt_valid <= 1'b0;
            alloc_evt_row   <= '0;
            alloc_evt_col   <= '0;
            err_bad_free    <= 1'b0;
        end else begin
            row_valid <= row_valid_nxt;
            for (int r = 0; r < NUM_ROWS; r++) begin
                busy[r] <= busy_nxt[r];
            end

            // A miss binds the ID to the claimed row. A hit rewrites the same
            // value, so the write needs no hit qualifier.
            if (fire) begin
                row_id[sel_row] <= ar_in_id;
            end

            // Output register: load on fire, otherwise drain on accept.
            if (fire) begin
                ar_out_valid <= 1'b1;
                ar_out_id    <= ID_WIDTH'({sel_row, sel_col});
                ar_out_addr  <= ar_in_addr;
                ar_out_len   <= ar_in_len;
                ar_out_size  <= ar_in_size;
                ar_out_burst <= ar_in_burst;
                ar_out_lock  <= ar_in_lock;
                ar_out_cache <= ar_in_cache;
                ar_out_prot  <= ar_in_prot;
                ar_out_qos   <= ar_in_qos;
            end else if (ar_out_ready) begin
                ar_out_valid <= 1'b0;
            end

            alloc_evt_valid <= fire;
            if (fire) begin
                alloc_evt_row <= sel_row;
                alloc_evt_col <= sel_col;
            end

            err_bad_free <= free_req && !busy_bit_at_free;
        end
    end

    // ------------------------------------------------------------------
    // Tag map: rows map 1:1 to IDs, so the column plays no part.
    // ------------------------------------------------------------------
    assign lookup_id = row_id[lookup_row];

    logic unused_lookup_col;
    assign unused_lookup_col = ^lookup_col;

endmodule

// File: tb/tb_ar_id_allocator.sv
module tb_ar_id_allocator;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int PW = AW + 8 + 3 + 2 + 1 + 4 + 3 + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          ar_in_valid = 1'b0;
  logic          ar_in_ready;
  logic [IW-1:0] ar_in_id = '0;
  logic [AW-1:0] ar_in_addr = '0;
  logic [7:0]    ar_in_len = '0;
  logic [2:0]    ar_in_size = '0;
  logic [1:0]    ar_in_burst = '0;
  logic          ar_in_lock = 1'b0;
  logic [3:0]    ar_in_cache = '0;
  logic [2:0]    ar_in_prot = '0;
  logic [3:0]    ar_in_qos = '0;
  logic          ar_out_valid;
  logic          ar_out_ready = 1'b0;
  logic [IW-1:0] ar_out_id;
  logic [AW-1:0] ar_out_addr;
  logic [7:0]    ar_out_len;
  logic [2:0]    ar_out_size;
  logic [1:0]    ar_out_burst;
  logic          ar_out_lock;
  logic [3:0]    ar_out_cache;
  logic [2:0]    ar_out_prot;
  logic [3:0]    ar_out_qos;
  logic          alloc_evt_valid;
  logic [1:0]    alloc_evt_row;
  logic [1:0]    alloc_evt_col;
  logic          free_req = 1'b0;
  logic [1:0]    free_row = '0;
  logic [1:0]    free_col = '0;
  logic [1:0]    lookup_row = '0;
  logic [1:0]    lookup_col = '0;
  logic [IW-1:0] lookup_id;
  logic          err_bad_free;

  ar_id_allocator #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .ID_WIDTH(IW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_in_valid(ar_in_valid), .ar_in_ready(ar_in_ready), .ar_in_id(ar_in_id),
    .ar_in_addr(ar_in_addr), .ar_in_len(ar_in_len), .ar_in_size(ar_in_size),
    .ar_in_burst(ar_in_burst), .ar_in_lock(ar_in_lock), .ar_in_cache(ar_in_cache),
    .ar_in_prot(ar_in_prot), .ar_in_qos(ar_in_qos),
    .ar_out_valid(ar_out_valid), .ar_out_ready(ar_out_ready), .ar_out_id(ar_out_id),
    .ar_out_addr(ar_out_addr), .ar_out_len(ar_out_len), .ar_out_size(ar_out_size),
    .ar_out_burst(ar_out_burst), .ar_out_lock(ar_out_lock), .ar_out_cache(ar_out_cache),
    .ar_out_prot(ar_out_prot), .ar_out_qos(ar_out_qos),
    .alloc_evt_valid(alloc_evt_valid), .alloc_evt_row(alloc_evt_row),
    .alloc_evt_col(alloc_evt_col),
    .free_req(free_req), .free_row(free_row), .free_col(free_col),
    .lookup_row(lookup_row), .lookup_col(lookup_col), .lookup_id(lookup_id),
    .err_bad_free(err_bad_free)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Rows: bound ID or -1; outstanding slots per row; last ID written per row
  // (the tag map keeps returning it after release).
  int            m_row_id  [NR];
  bit            m_slot    [NR][NC];
  logic [IW-1:0] m_last_id [NR];
  bit            m_out_valid;
  int            m_out_tag;
  logic [PW-1:0] m_out_pay;
  bit            m_evt;
  int            m_evt_row;
  int            m_evt_col;
  bit            m_err;

  function automatic logic [PW-1:0] dut_payload();
    return {ar_out_addr, ar_out_len, ar_out_size, ar_out_burst, ar_out_lock,
            ar_out_cache, ar_out_prot, ar_out_qos};
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NR; r++) begin
      m_row_id[r]  = -1;
      m_last_id[r] = '0;
      for (int c = 0; c < NC; c++) m_slot[r][c] = 1'b0;
    end
    m_out_valid = 1'b0;
    m_out_tag   = 0;
    m_out_pay   = '0;
    m_evt       = 1'b0;
    m_evt_row   = 0;
    m_evt_col   = 0;
    m_err       = 1'b0;
  endfunction

  // Where would a request with this ID go right now?
  function automatic void model_pick(input logic [IW-1:0] id, output bit ok,
                                     output bit miss, output int row, output int col);
    ok = 1'b0; miss = 1'b1; row = 0; col = 0;
    for (int r = 0; r < NR; r++)
      if (m_row_id[r] == int'(id)) begin miss = 1'b0; row = r; end
    if (!miss) begin
      for (int c = 0; c < NC; c++)
        if (!ok && !m_slot[row][c]) begin ok = 1'b1; col = c; end
    end else begin
      for (int r = 0; r < NR; r++)
        if (!ok && m_row_id[r] < 0) begin ok = 1'b1; row = r; end
    end
  endfunction

  function automatic int row_count(input int r);
    int n = 0;
    for (int c = 0; c < NC; c++) n += int'(m_slot[r][c]);
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    ar_in_valid  = 1'b0;
    ar_out_ready = 1'b0;
    free_req     = 1'b0;
    lookup_row   = '0;
    rst_n        = 1'b0;
    #2;
    check("rst_out_valid", 64'(ar_out_valid), 64'd0);
    check("rst_out_id", 64'(ar_out_id), 64'd0);
    check("rst_out_addr", 64'(ar_out_addr), 64'd0);
    check("rst_evt_valid", 64'(alloc_evt_valid), 64'd0);
    check("rst_evt_slot", 64'({alloc_evt_row, alloc_evt_col}), 64'd0);
    check("rst_err", 64'(err_bad_free), 64'd0);
    check("rst_lookup", 64'(lookup_id), 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, advance
  // the model across the posedge, then check registered outputs.
  task automatic step(input bit v, input logic [IW-1:0] id, input bit ordy,
                      input bit fr, input logic [1:0] frow, input logic [1:0] fcol);
    bit ok, miss, fire, pre_busy, exp_ready;
    int row, col;
    logic [PW-1:0] pay;
    @(negedge clk);
    pay = {$urandom(), 8'($urandom()), 3'($urandom()), 2'($urandom()), 1'($urandom()),
           4'($urandom()), 3'($urandom()), 4'($urandom())};
    ar_in_valid = v;
    ar_in_id    = id;
    {ar_in_addr, ar_in_len, ar_in_size, ar_in_burst, ar_in_lock,
     ar_in_cache, ar_in_prot, ar_in_qos} = pay;
    ar_out_ready = ordy;
    free_req     = fr;
    free_row     = frow;
    free_col     = fcol;
    lookup_row   = 2'($urandom_range(0, NR - 1));
    lookup_col   = 2'($urandom_range(0, NC - 1));
    #1;
    model_pick(id, ok, miss, row, col);
    exp_ready = ok && (!m_out_valid || ordy);
    check("in_ready", 64'(ar_in_ready), 64'(exp_ready));
    check("lookup_id", 64'(lookup_id), 64'(m_last_id[lookup_row]));
    fire     = v && exp_ready;
    pre_busy = m_slot[frow][fcol];

    @(posedge clk);
    #1;
    m_err = fr && !pre_busy;
    m_evt = fire;
    if (fire) begin
      m_evt_row   = row;
      m_evt_col   = col;
      m_out_valid = 1'b1;
      m_out_tag   = row * NC + col;
      m_out_pay   = pay;
      m_slot[row][col] = 1'b1;
      if (miss) begin
        m_row_id[row]  = int'(id);
        m_last_id[row] = id;
      end
    end else if (ordy) begin
      m_out_valid = 1'b0;
    end
    if (fr && pre_busy) begin
      m_slot[frow][fcol] = 1'b0;
      if (row_count(int'(frow)) == 0) m_row_id[frow] = -1;
    end

    check("out_valid", 64'(ar_out_valid), 64'(m_out_valid));
    if (m_out_valid) begin
      check("out_id", 64'(ar_out_id), 64'(m_out_tag));
      check("out_payload", 64'(dut_payload()), 64'(m_out_pay));
    end
    check("evt_valid", 64'(alloc_evt_valid), 64'(m_evt));
    if (m_evt) check("evt_slot", 64'({alloc_evt_row, alloc_evt_col}),
                     64'(m_evt_row * NC + m_evt_col));
    check("err_bad_free", 64'(err_bad_free), 64'(m_err));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // Single AR id=5 lands in row 0 col 0; event lasts one cycle.
    step(1, 4'd5, 1, 0, 0, 0);
    check("d1_out_id", 64'(ar_out_id), 64'd0);
    lookup_row = 2'd0;
    #1;
    check("d1_lookup", 64'(lookup_id), 64'd5);
    step(0, 4'd0, 1, 0, 0, 0);
    check("d1_evt_once", 64'(alloc_evt_valid), 64'd0);

    // Fill row 0 with id=3, fifth stalls, a free of col 1 lets it through.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 4'd3, 1, 0, 0, 0);
      check("d2_col", 64'({alloc_evt_row, alloc_evt_col}), 64'(i));
    end
    step(1, 4'd3, 1, 0, 0, 0);
    check("d2_stall_evt", 64'(alloc_evt_valid), 64'd0);
    step(1, 4'd3, 1, 1, 2'd0, 2'd1);
    step(1, 4'd3, 1, 0, 0, 0);
    check("d2_reuse_col1", 64'({alloc_evt_valid, alloc_evt_row, alloc_evt_col}), 64'h11);

    // IDs 1..4 bind all rows; 5 stalls until row 2 is released.
    do_reset();
    for (int i = 1; i <= 4; i++) step(1, IW'(i), 1, 0, 0, 0);
    step(1, 4'd5, 1, 0, 0, 0);
    check("d3_stall", 64'(alloc_evt_valid), 64'd0);
    step(1, 4'd5, 1, 1, 2'd2, 2'd0);
    step(1, 4'd5, 1, 0, 0, 0);
    check("d3_rebind", 64'({alloc_evt_valid, alloc_evt_row, alloc_evt_col}), 64'h18);
    lookup_row = 2'd2;
    #1;
    check("d3_lookup", 64'(lookup_id), 64'd5);

    // Slave back-pressure holds the output; accept reloads the same cycle.
    do_reset();
    step(1, 4'd7, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 4'd8, 0, 0, 0, 0);
    step(1, 4'd8, 1, 0, 0, 0);
    check("d4_reload_id", 64'({ar_out_valid, ar_out_id}), 64'h14);

    // Fire and free in the same row and cycle: pre-free bitmap wins.
    do_reset();
    step(1, 4'd3, 1, 0, 0, 0);
    step(1, 4'd3, 1, 0, 0, 0);
    step(1, 4'd3, 1, 1, 2'd0, 2'd0);
    check("d5_col2", 64'(alloc_evt_col), 64'd2);
    step(1, 4'd3, 1, 0, 0, 0);
    check("d5_col0_reuse", 64'({alloc_evt_row, alloc_evt_col}), 64'd0);

    // Free of an idle slot pulses the error exactly once.
    do_reset();
    step(0, 4'd0, 1, 1, 2'd3, 2'd3);
    check("d6_err", 64'(err_bad_free), 64'd1);
    step(0, 4'd0, 1, 0, 0, 0);
    check("d6_err_once", 64'(err_bad_free), 64'd0);

    // Asynchronous reset while an AR is held at the output.
    do_reset();
    step(1, 4'd9, 0, 0, 0, 0);
    step(1, 4'd9, 0, 0, 0, 0);
    check("d7_held", 64'(ar_out_valid), 64'd1);
    lookup_row = 2'd0;
    rst_n = 1'b0;
    #1;
    check("d7_async_valid", 64'(ar_out_valid), 64'd0);
    check("d7_async_lookup", 64'(lookup_id), 64'd0);
    do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit fr;
      logic [1:0] frow, fcol;
      fr   = ($urandom_range(0, 2) == 0);
      frow = 2'($urandom_range(0, NR - 1));
      fcol = 2'($urandom_range(0, NC - 1));
      if (fr && $urandom_range(0, 3) != 0) begin
        int start = $urandom_range(0, NR * NC - 1);
        for (int k = 0; k < NR * NC; k++) begin
          int s = (start + k) % (NR * NC);
          if (m_slot[s / NC][s % NC]) begin
            frow = 2'(s / NC);
            fcol = 2'(s % NC);
            break;
          end
        end
      end
      step($urandom_range(0, 3) != 0, IW'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, fr, frow, fcol);
      if (n % 1000 == 999) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
